fft_input_framer: RTL and testbench

- Feeds the FFT core's data and config slave channels. It sits between the DMA MM2S stream (real 16-bit samples) and the FFT data input.
- Packs each real sample as {imag=0, real} into 32-bit words.
- Generates m_axis_tlast from an internal sample counter every FFT_LEN samples.
- Issues the FFT config word once after reset, and again on request.
- Output is fully registered with a 2-entry skid buffer, so it sustains 1 sample/cycle under arbitrary backpressure.

---
 rtl/fft_input_framer.sv | 175 +++++++++++++++++
 tb/tb_fft_input_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_framer.sv
// fft_input_framer
//   Packs real 16-bit DMA samples as {imag=0, real} for the FFT data channel,
//   marks every FFT_LEN-th sample with tlast from an internal counter, and
//   sends the FFT config word once after reset and again on cfg_restart.
//   The output path is a registered stage plus one skid entry, so the input
//   ready is a flop and the stream sustains 1 sample/cycle under backpressure.
//
// Ports
//   aclk, aresetn           clock, async active-low reset (sync release)
//   s_axis_*                16-bit real samples from DMA (tlast is only checked)
//   m_axis_*                32-bit {16'h0, real} samples to the FFT
//   m_axis_config_*         FFT config word channel
//   cfg_restart             pulse: resend config at the next frame boundary
//   frame_err / err_clear   sticky early-tlast flag and its clear pulse
//
// Optional (macro FFT_FRAMER_STATUS_EN):
//   frame_count[31:0]       frames handed to the FFT (wraps)
//   tlast_err_count[15:0]   frame_err set events (saturates, cleared by err_clear)
module fft_input_framer #(
  parameter int                   FFT_LEN   = 1024,
  parameter int                   CFG_WIDTH = 16,
  parameter logic [CFG_WIDTH-1:0] CFG_WORD  = 16'h0001
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [15:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [CFG_WIDTH-1:0] m_axis_config_tdata,
  output logic                 m_axis_config_tvalid,
  input  logic                 m_axis_config_tready,
  input  logic                 cfg_restart,
  output logic                 frame_err,
  input  logic                 err_clear
`ifdef FFT_FRAMER_STATUS_EN
  ,
  output logic [31:0]          frame_count,
  output logic [15:0]          tlast_err_count
`endif
);

  localparam int            IW       = $clog2(FFT_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_LEN - 1);

  typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          pend, pend_n;
  logic          rdy, rdy_n;
  logic          cfg_v, cfg_v_n;
  logic          out_v, out_v_n, out_l, out_l_n;
  logic [15:0]   out_d, out_d_n;
  logic          sk_v, sk_v_n, sk_l, sk_l_n;
  logic [15:0]   sk_d, sk_d_n;
  logic          ferr, ferr_set;
  logic          acc, pop, in_last;

  assign acc     = rdy & s_axis_tvalid;
  assign pop     = out_v & m_axis_tready;
  assign in_last = (idx == LAST_IDX);
  assign ferr_set = acc & s_axis_tlast & ~in_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_CFG;
      idx   <= '0;
      pend  <= 1'b0;
      rdy   <= 1'b0;
      cfg_v <= 1'b0;
      out_v <= 1'b0;
      out_d <= '0;
      out_l <= 1'b0;
      sk_v  <= 1'b0;
      sk_d  <= '0;
      sk_l  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      pend  <= pend_n;
      rdy   <= rdy_n;
      cfg_v <= cfg_v_n;
      out_v <= out_v_n;
      out_d <= out_d_n;
      out_l <= out_l_n;
      sk_v  <= sk_v_n;
      sk_d  <= sk_d_n;
      sk_l  <= sk_l_n;
      ferr  <= ferr_set | (ferr & ~err_clear);
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = acc ? idx + 1'b1 : idx;   // power-of-2 length: wrap is free
    out_v_n = out_v;
    out_d_n = out_d;
    out_l_n = out_l;
    sk_v_n  = sk_v;
    sk_d_n  = sk_d;
    sk_l_n  = sk_l;

    // Output stage refills from the skid entry first to keep order. When the
    // skid entry is full, rdy was already low, so no sample arrives alongside.
    if (!out_v || pop) begin
      if (sk_v) begin
        out_v_n = 1'b1;
        out_d_n = sk_d;
        out_l_n = sk_l;
        sk_v_n  = 1'b0;
      end else begin
        out_v_n = acc;
        if (acc) begin
          out_d_n = s_axis_tdata;
          out_l_n = in_last;
        end
      end
    end else if (acc) begin
      sk_v_n = 1'b1;
      sk_d_n = s_axis_tdata;
      sk_l_n = in_last;
    end

    // Restart requests arriving during a config send are redundant.
    pend_n = pend | (cfg_restart & (state != S_CFG));

    unique case (state)
      S_CFG:   if (cfg_v && m_axis_config_tready) state_n = S_RUN;
      S_RUN:   if (pend && idx == '0) state_n = S_DRAIN;
      S_DRAIN: if (!out_v && !sk_v) begin
                 state_n = S_CFG;
                 pend_n  = 1'b0;
               end
      default: state_n = S_CFG;
    endcase

    cfg_v_n = (state_n == S_CFG);
    // Ready is registered, so it must already drop in the cycle that lands on
    // a frame boundary with a restart pending; otherwise a sample of the next
    // frame would slip in ahead of the config resend.
    rdy_n = (state_n == S_RUN) && !sk_v_n && !(pend_n && idx_n == '0);
  end

  assign s_axis_tready        = rdy;
  assign m_axis_tdata         = {16'h0000, out_d};
  assign m_axis_tvalid        = out_v;
  assign m_axis_tlast         = out_l;
  assign m_axis_config_tdata  = CFG_WORD;
  assign m_axis_config_tvalid = cfg_v;
  assign frame_err            = ferr;

`ifdef FFT_FRAMER_STATUS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count     <= '0;
      tlast_err_count <= '0;
    end else begin
      if (pop && out_l) frame_count <= frame_count + 32'd1;
      if (ferr_set) begin
        if (err_clear)                      tlast_err_count <= 16'd1;
        else if (tlast_err_count != 16'hFFFF) tlast_err_count <= tlast_err_count + 16'd1;
      end else if (err_clear) begin
        tlast_err_count <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_input_framer.sv
module tb_fft_input_framer;
  localparam int FL = 8;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [15:0] c_tdata;
  logic        c_tvalid, c_tready;
  logic        cfg_restart, frame_err, err_clear;
`ifdef FFT_FRAMER_STATUS_EN
  logic [31:0] frame_count;
  logic [15:0] tlast_err_count;
`endif

  fft_input_framer #(.FFT_LEN(FL), .CFG_WIDTH(16), .CFG_WORD(16'h0001)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .m_axis_config_tdata(c_tdata), .m_axis_config_tvalid(c_tvalid),
    .m_axis_config_tready(c_tready),
    .cfg_restart(cfg_restart), .frame_err(frame_err), .err_clear(err_clear)
`ifdef FFT_FRAMER_STATUS_EN
    , .frame_count(frame_count), .tlast_err_count(tlast_err_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected output stream: {last, data} per accepted sample, in order.
  logic [16:0] q[$];
  int   cnt;          // accepted samples mod FL since reset
  logic m_err;        // expected frame_err
  logic m_cfg;        // a config send is expected to be in progress
  logic m_block;      // restart requested: stop at the next frame boundary
  int   cfg_hs, cyc, ocnt, first_last;
  logic lat_mode, cap_en, rnd_rdy;
  logic [15:0] cap_d[16];
  logic        cap_l[16];
  int   cap_n;
  logic prev_mv, prev_mr, prev_ml, prev_cv, prev_cr, prev_acc;
  logic [31:0] prev_md;

  initial begin
    cyc = 0; cfg_hs = 0; cap_n = 0; lat_mode = 0; cap_en = 0; rnd_rdy = 0;
  end

  always @(negedge aclk) begin
    logic [16:0] f;
    logic a;
    cyc++;
    if (!aresetn) begin
      q.delete();
      cnt = 0; m_err = 0; m_cfg = 1; m_block = 0; ocnt = 0; first_last = 0;
      prev_mv = 0; prev_mr = 0; prev_ml = 0; prev_md = 0;
      prev_cv = 0; prev_cr = 0; prev_acc = 0;
    end else begin
      if (prev_mv && !prev_mr) begin
        chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
        chk("stall_data", m_tdata, prev_md);
        chk("stall_last", {31'd0, m_tlast}, {31'd0, prev_ml});
      end
      if (prev_cv && !prev_cr) chk("cfg_valid_held", {31'd0, c_tvalid}, 32'd1);
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
      if (c_tvalid) begin
        chk("cfg_tdata", {16'd0, c_tdata}, 32'h0001);
        chk("ready_low_in_cfg", {31'd0, s_tready}, 32'd0);
      end
      if (lat_mode) chk("latency", {31'd0, m_tvalid}, {31'd0, prev_acc});

      if (m_tvalid && m_tready) begin
        if (q.size() == 0) chk("spurious_output", {31'd0, m_tvalid}, 32'd0);
        else begin
          f = q.pop_front();
          chk("out_data", m_tdata, {16'd0, f[15:0]});
          chk("out_last", {31'd0, m_tlast}, {31'd0, f[16]});
        end
        ocnt++;
        if (m_tlast && first_last == 0) first_last = ocnt;
        if (cap_en && cap_n < 16) begin
          cap_d[cap_n] = m_tdata[15:0]; cap_l[cap_n] = m_tlast; cap_n++;
        end
      end

      if (c_tvalid && !m_cfg) begin
        chk("resend_after_drain",
            {31'd0, (q.size() == 0) && m_block && (cnt == 0) && !m_tvalid}, 32'd1);
        m_cfg = 1;
      end

      a = s_tvalid && s_tready;
      if (a) begin
        chk("accept_allowed", {31'd0, !m_cfg && !(m_block && cnt == 0)}, 32'd1);
        q.push_back({cnt == FL - 1, s_tdata});
        if (s_tlast && cnt != FL - 1) m_err = 1;
        else if (err_clear) m_err = 0;
        cnt = (cnt + 1) % FL;
      end else if (err_clear) m_err = 0;

      if (cfg_restart && !m_cfg) m_block = 1;
      if (c_tvalid && c_tready) begin
        m_cfg = 0; m_block = 0; cfg_hs++;
      end

      prev_mv = m_tvalid; prev_mr = m_tready; prev_ml = m_tlast; prev_md = m_tdata;
      prev_cv = c_tvalid; prev_cr = c_tready; prev_acc = a;
    end
  end

  always @(posedge aclk) if (rnd_rdy) begin
    #1 m_tready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int b = 0;
    logic a;
    s_tdata = d; s_tlast = l; s_tvalid = 1;
    do begin
      @(negedge aclk); a = s_tready;
      @(posedge aclk); #1; b++;
    end while (!a && b < 300);
    if (!a) chk("send_timeout", {31'd0, a}, 32'd1);
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic wait_cfg(input int target);
    int b = 0;
    while (cfg_hs < target && b < 200) begin step(1); b++; end
    chk("cfg_handshakes", cfg_hs, target);
  endtask

  task automatic drain();
    int b = 0;
    while ((q.size() != 0 || m_tvalid) && b < 300) begin step(1); b++; end
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int t0, h0;
    aresetn = 0; s_tdata = 0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
    c_tready = 0; cfg_restart = 0; err_clear = 0;
    #22;
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_cfg_valid", {31'd0, c_tvalid}, 32'd0);
    chk("rst_cfg_tdata", {16'd0, c_tdata}, 32'h0001);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge aclk); #1 aresetn = 1;

    // config held off 5 cycles, then accepted exactly once
    step(5);
    chk("cfg_wait_valid", {31'd0, c_tvalid}, 32'd1);
    chk("cfg_wait_ready", {31'd0, s_tready}, 32'd0);
    c_tready = 1;
    wait_cfg(1);
    step(3);
    chk("cfg_once", cfg_hs, 1);
    chk("ready_after_cfg", {31'd0, s_tready}, 32'd1);

    // samples 1..16, downstream always ready
    m_tready = 1; step(1);
    lat_mode = 1; cap_en = 1; t0 = cyc;
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
    chk("throughput_cycles", cyc - t0, 16);
    step(3); lat_mode = 0; cap_en = 0;
    chk("captured", cap_n, 16);
    for (int i = 0; i < 16; i++) begin
      chk("lit_data", {16'd0, cap_d[i]}, 32'(i + 1));
      chk("lit_last", {31'd0, cap_l[i]}, {31'd0, (i == 7) || (i == 15)});
    end

    // random backpressure and input gaps
    rnd_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      step($urandom_range(0, 1));
      send(16'($urandom), 1'b0);
    end
    rnd_rdy = 0; step(1); m_tready = 1; drain();

    // early upstream tlast on sample 5
    for (int i = 1; i <= 8; i++) begin
      send(16'(16'h100 + i), i == 5);
      if (i == 5) chk("lit_ferr_set", {31'd0, frame_err}, 32'd1);
    end
    drain();
    chk("lit_ferr_sticky", {31'd0, frame_err}, 32'd1);
    err_clear = 1; step(1); err_clear = 0;
    chk("lit_ferr_clear", {31'd0, frame_err}, 32'd0);

    // restart at sample 3: frame completes, then config, then sample 9
    rnd_rdy = 1;
    for (int i = 1; i <= 3; i++) send(16'(16'h200 + i), 1'b0);
    cfg_restart = 1; step(1); cfg_restart = 0;
    h0 = cfg_hs;
    for (int i = 4; i <= 8; i++) send(16'(16'h200 + i), 1'b0);
    send(16'h0209, 1'b0);
    chk("restart_cfg_before_next", cfg_hs, h0 + 1);
    for (int i = 10; i <= 16; i++) send(16'(16'h200 + i), 1'b0);
    rnd_rdy = 0; step(1); m_tready = 1; drain();

    // reset mid-frame after sample 4, output stage still holding data
    for (int i = 1; i <= 4; i++) send(16'(16'h300 + i), 1'b0);
    aresetn = 0; #1;
    chk("async_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("async_m_tdata", m_tdata, 32'd0);
    chk("async_m_tlast", {31'd0, m_tlast}, 32'd0);
    chk("async_s_tready", {31'd0, s_tready}, 32'd0);
    chk("async_cfg_valid", {31'd0, c_tvalid}, 32'd0);
    step(2); aresetn = 1;
    h0 = cfg_hs;
    wait_cfg(h0 + 1);
    for (int i = 1; i <= 8; i++) send(16'(16'h400 + i), 1'b0);
    drain();
    chk("lit_tlast_after_reset", first_last, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
